// File: rtl/ising_sweep_if.sv
// rtl/ising_sweep_if.sv - host/array-side bundle of the Ising sweep scheduler
// Optional snapshot handshake signals appear when ISING_SNAPSHOT_EN is defined.
interface ising_sweep_if #(
    parameter int SWEEP_W = 16,
    parameter int SEED_W  = 8
);
    logic               start;
    logic [SWEEP_W-1:0] num_sweeps;
    logic               abort;
    logic               enable_white;
    logic               enable_grey;
    logic               commit_white;
    logic               commit_grey;
    logic [SEED_W-1:0]  seed_val;
    logic [SWEEP_W-1:0] sweep_count;
    logic               busy;
    logic               done;
    logic               aborted;
`ifdef ISING_SNAPSHOT_EN
    logic               snap_valid;
    logic               snap_ready;

    modport slave (
        input  start, num_sweeps, abort, snap_ready,
        output enable_white, enable_grey, commit_white, commit_grey,
               seed_val, sweep_count, busy, done, aborted, snap_valid
    );
    modport master (
        output start, num_sweeps, abort, snap_ready,
        input  enable_white, enable_grey, commit_white, commit_grey,
               seed_val, sweep_count, busy, done, aborted, snap_valid
    );
`else
    modport slave (
        input  start, num_sweeps, abort,
        output enable_white, enable_grey, commit_white, commit_grey,
               seed_val, sweep_count, busy, done, aborted
    );
    modport master (
        output start, num_sweeps, abort,
        input  enable_white, enable_grey, commit_white, commit_grey,
               seed_val, sweep_count, busy, done, aborted
    );
`endif
endinterface

// File: rtl/ising_sweep_scheduler.sv
// rtl/ising_sweep_scheduler.sv - checkerboard Metropolis sweep sequencer for the 8x8 spin array
// Define ISING_SNAPSHOT_EN to pause in SNAP_WAIT between sweeps until snap_ready.
module ising_sweep_scheduler #(
    parameter int SWEEP_W       = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int SEED_W        = 8
) (
    input logic         clk,
    input logic         reset_n,
    ising_sweep_if.slave bus
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_RUN,
        S_W_COMMIT,
        S_G_RUN,
        S_G_COMMIT,
        S_SWEEP_END,
        S_DONE,
        S_SNAP_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SWEEP_W-1:0] target_q, target_d;
    logic [SWEEP_W-1:0] count_q, count_d;
    logic [SEED_W-1:0]  seed_q, seed_d;
    logic               abort_hit;

    logic en_white_q, en_grey_q, commit_white_q, commit_grey_q;
    logic busy_q, done_q, aborted_q, snap_valid_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        count_d   = count_q;
        seed_d    = seed_q;
        abort_hit = 1'b0;

        // The RNG seed only moves while a sweep is actually in progress.
        if (busy_q && state_q != S_SNAP_WAIT) begin
            seed_d = seed_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    count_d = '0;
                    cnt_d   = '0;
                    if (bus.num_sweeps == '0) begin
                        state_d = S_DONE;
                    end else begin
                        target_d = bus.num_sweeps;
                        state_d  = S_W_RUN;
                    end
                end
            end
            S_W_RUN: begin
                if (cnt_q == CNT_LAST) state_d = S_W_COMMIT;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            S_W_COMMIT: begin
                state_d = S_G_RUN;
                cnt_d   = '0;
            end
            S_G_RUN: begin
                if (cnt_q == CNT_LAST) state_d = S_G_COMMIT;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            S_G_COMMIT: begin
                state_d = S_SWEEP_END;
                cnt_d   = '0;
            end
            S_SWEEP_END: begin
                count_d = count_q + 1'b1;
                if (count_d == target_q) begin
                    state_d = S_DONE;
                end else begin
`ifdef ISING_SNAPSHOT_EN
                    state_d = S_SNAP_WAIT;
`else
                    state_d = S_W_RUN;
`endif
                end
            end
            S_SNAP_WAIT: begin
`ifdef ISING_SNAPSHOT_EN
                if (bus.snap_ready) state_d = S_W_RUN;
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every busy-state transition; DONE already counts as finished.
        if (bus.abort && state_q != S_IDLE && state_q != S_DONE) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            abort_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            target_q       <= '0;
            count_q        <= '0;
            seed_q         <= '0;
            en_white_q     <= 1'b0;
            en_grey_q      <= 1'b0;
            commit_white_q <= 1'b0;
            commit_grey_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
            snap_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            target_q       <= target_d;
            count_q        <= count_d;
            seed_q         <= seed_d;
            en_white_q     <= (state_d == S_W_RUN) || (state_d == S_W_COMMIT);
            en_grey_q      <= (state_d == S_G_RUN) || (state_d == S_G_COMMIT);
            commit_white_q <= (state_d == S_W_COMMIT);
            commit_grey_q  <= (state_d == S_G_COMMIT);
            busy_q         <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q         <= (state_d == S_DONE);
            aborted_q      <= abort_hit;
            snap_valid_q   <= (state_d == S_SNAP_WAIT);
        end
    end

    assign bus.enable_white = en_white_q;
    assign bus.enable_grey  = en_grey_q;
    // A commit in the abort cycle must never reach the lattice register.
    assign bus.commit_white = commit_white_q & ~abort_hit;
    assign bus.commit_grey  = commit_grey_q & ~abort_hit;
    assign bus.seed_val     = seed_q;
    assign bus.sweep_count  = count_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
`ifdef ISING_SNAPSHOT_EN
    assign bus.snap_valid   = snap_valid_q;
`else
    logic unused_snap;
    assign unused_snap = snap_valid_q;
`endif
endmodule
